// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad scanner with press/release debounce
//                  and a four-digit hex entry shift register.
// Revision       : 1.0
// ============================================================================
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 500000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clear,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] entry
);

   typedef enum logic [1:0] {
      ST_SCAN       = 2'd0,
      ST_DEBOUNCE   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } state_t;

   localparam int unsigned c_DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned c_DB_W  = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CNT - 1);

   state_t              r_state, w_state;
   logic [1:0]          r_col, w_col;
   logic [1:0]          r_row_idx, w_row_idx;
   logic [c_DIV_W-1:0]  r_div, w_div;
   logic [c_DB_W-1:0]   r_db, w_db;
   logic [3:0]          r_key_code, w_key_code;
   logic                r_key_valid, w_key_valid;
   logic                r_key_held, w_key_held;
   logic [15:0]         r_entry, w_entry;
   logic                w_accept;
   logic                w_row_bit;
   logic [1:0]          w_hit_idx;

   // Lowest low row wins when several keys in one column are down.
   always_comb begin
      w_hit_idx = 2'd0;
      casez (row)
         4'b???0: w_hit_idx = 2'd0;
         4'b??01: w_hit_idx = 2'd1;
         4'b?011: w_hit_idx = 2'd2;
         4'b0111: w_hit_idx = 2'd3;
         default: w_hit_idx = 2'd0;
      endcase
   end

   assign w_row_bit = row[r_row_idx];

   always_comb begin
      w_state     = r_state;
      w_col       = r_col;
      w_row_idx   = r_row_idx;
      w_div       = r_div;
      w_db        = r_db;
      w_key_code  = r_key_code;
      w_key_valid = 1'b0;
      w_key_held  = r_key_held;
      w_accept    = 1'b0;

      case (r_state)
         ST_SCAN: begin
            if (r_div == c_DIV_LAST) begin
               w_div = '0;
               if (row != 4'hF) begin
                  w_row_idx = w_hit_idx;
                  w_db      = '0;
                  w_state   = ST_DEBOUNCE;
               end else begin
                  w_col = r_col + 2'd1;
               end
            end else begin
               w_div = r_div + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (w_row_bit) begin
               w_state = ST_SCAN;
               w_col   = r_col + 2'd1;
               w_div   = '0;
            end else if (r_db == c_DB_LAST) begin
               w_accept = 1'b1;
               w_db     = '0;
               w_state  = ST_HELD;
            end else begin
               w_db = r_db + 1'b1;
            end
         end
         ST_HELD: begin
            if (w_row_bit) begin
               w_db    = '0;
               w_state = ST_RELEASE_DB;
            end
         end
         ST_RELEASE_DB: begin
            if (!w_row_bit) begin
               w_state = ST_HELD;
            end else if (r_db == c_DB_LAST) begin
               w_key_held = 1'b0;
               w_db       = '0;
               w_div      = '0;
               w_col      = r_col + 2'd1;
               w_state    = ST_SCAN;
            end else begin
               w_db = r_db + 1'b1;
            end
         end
         default: w_state = ST_SCAN;
      endcase

      if (w_accept) begin
         w_key_valid = 1'b1;
         w_key_code  = {r_row_idx, r_col};
         w_key_held  = 1'b1;
      end

      // A clear coinciding with acceptance keeps only the new digit.
      if (clear) begin
         w_entry = w_accept ? {12'h000, w_key_code} : 16'h0000;
      end else if (w_accept) begin
         w_entry = {r_entry[11:0], w_key_code};
      end else begin
         w_entry = r_entry;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= ST_SCAN;
         r_col       <= 2'd0;
         r_row_idx   <= 2'd0;
         r_div       <= '0;
         r_db        <= '0;
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_entry     <= 16'h0000;
      end else begin
         r_state     <= w_state;
         r_col       <= w_col;
         r_row_idx   <= w_row_idx;
         r_div       <= w_div;
         r_db        <= w_db;
         r_key_code  <= w_key_code;
         r_key_valid <= w_key_valid;
         r_key_held  <= w_key_held;
         r_entry     <= w_entry;
      end
   end

   assign col       = ~(4'b0001 << r_col);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;
   assign entry     = r_entry;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : self-checking bench, physical key model plus scoreboard
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        clear = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] entry;

   logic        key_down = 1'b0;
   logic [1:0]  key_r = 2'd0;
   logic [1:0]  key_c = 2'd0;

   always #5 CLK = ~CLK;

   // A pressed key connects its row to its column only while that column is driven low.
   assign row = (key_down && (col == ~(4'b0001 << key_c))) ? ~(4'b0001 << key_r) : 4'hF;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .row       (row),
      .col       (col),
      .clear     (clear),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .entry     (entry)
   );

   typedef struct {
      logic [3:0]  code;
      logic [15:0] entry;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         sb_e;
   logic [15:0] sb_entry = 16'h0000;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: every key_valid pulse must match the oldest expected press.
   always @(negedge CLK) begin
      if (RESET) begin
         prev_valid <= 1'b0;
      end else begin
         if (key_valid) begin
            check("valid_width", 32'(prev_valid), 0);
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: pulse with key_code=%0h, expected none at %0t",
                        key_code, $time);
            end else begin
               sb_e = sb_q.pop_front();
               check("valid_code", 32'(key_code), 32'(sb_e.code));
               check("valid_entry", 32'(entry), 32'(sb_e.entry));
            end
         end
         prev_valid <= key_valid;
      end
   end

   // Returns just after the edge on which col first takes the target value.
   task automatic sync_col(input logic [3:0] target);
      logic [3:0] prev;
      bit         found;
      found = 1'b0;
      prev  = col;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge CLK); #1;
         if (col == target && prev != target) found = 1'b1;
         prev = col;
      end
      check("col_sync", 32'(found), 1);
   endtask

   task automatic press(input logic [3:0] code, input bit clr_acc, input bit glitch);
      int lat;
      bit dropped;
      sync_col(~(4'b0001 << code[1:0]));
      sb_entry = clr_acc ? {12'h000, code} : {sb_entry[11:0], code};
      sb_q.push_back('{code, sb_entry});
      key_r    = code[3:2];
      key_c    = code[1:0];
      key_down = 1'b1;
      if (clr_acc) begin
         // Acceptance edge is 12 edges after the column becomes active.
         repeat (11) @(posedge CLK);
         #1 clear = 1'b1;
         @(posedge CLK);
         #1 clear = 1'b0;
      end
      lat = 0;
      while (!key_held && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
      check("held_rise", 32'(key_held), 1);
      if (glitch) begin
         dropped = 1'b0;
         repeat (4) @(posedge CLK);
         #1 key_down = 1'b0;
         repeat (3) begin
            @(posedge CLK); #1;
            if (!key_held) dropped = 1'b1;
         end
         key_down = 1'b1;
         repeat (12) begin
            @(posedge CLK); #1;
            if (!key_held) dropped = 1'b1;
         end
         check("glitch_held", 32'(dropped), 0);
      end
      repeat (8) @(posedge CLK);
      #1 key_down = 1'b0;
      lat = 0;
      while (key_held && lat < 30) begin
         @(posedge CLK); #1;
         lat++;
      end
      check("release_lat_8to9", 32'(lat >= 8 && lat <= 9), 1);
      check("key_code_hold", 32'(key_code), 32'(code));
      check("entry_after", 32'(entry), 32'(sb_entry));
      repeat (2) @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic [3:0]  exp_col;
      logic        exp_valid;
      logic [15:0] exp_entry;
   } rst_vec_t;

   typedef struct {
      int          op;        // 0 press, 1 press with coincident clear, 2 clear alone, 3 press with glitch
      logic [3:0]  code;
      logic [15:0] exp_entry;
   } key_vec_t;

   rst_vec_t rt[17];
   key_vec_t kt[10];

   initial begin
      for (int i = 0; i < 17; i++) begin
         rt[i].exp_col   = 4'(~(4'b0001 << ((i / 4) % 4)));
         rt[i].exp_valid = 1'b0;
         rt[i].exp_entry = 16'h0000;
      end
      kt[0] = '{2, 4'h0, 16'h0000};
      kt[1] = '{0, 4'h1, 16'h0001};
      kt[2] = '{0, 4'h2, 16'h0012};
      kt[3] = '{0, 4'h3, 16'h0123};
      kt[4] = '{0, 4'h4, 16'h1234};
      kt[5] = '{0, 4'h5, 16'h2345};
      kt[6] = '{2, 4'h0, 16'h0000};
      kt[7] = '{0, 4'h6, 16'h0006};
      kt[8] = '{1, 4'h7, 16'h0007};
      kt[9] = '{3, 4'hF, 16'h007F};

      // Reset state and free-running scan
      repeat (3) @(negedge CLK);
      check("rst_col", 32'(col), 'hE);
      check("rst_code", 32'(key_code), 0);
      check("rst_valid", 32'(key_valid), 0);
      check("rst_held", 32'(key_held), 0);
      check("rst_entry", 32'(entry), 0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge CLK);
         check("scan_col", 32'(col), 32'(rt[i].exp_col));
         check("scan_valid", 32'(key_valid), 32'(rt[i].exp_valid));
         check("scan_entry", 32'(entry), 32'(rt[i].exp_entry));
      end

      // Single press of key 9 on column 1, 20 cycles held
      press(4'h9, 1'b0, 1'b0);
      check("single_entry", 32'(entry), 'h0009);

      // Bounce on column 0 shorter than the debounce window
      sync_col(4'b1110);
      key_r    = 2'd0;
      key_c    = 2'd0;
      key_down = 1'b1;
      repeat (5) @(posedge CLK);
      #1 key_down = 1'b0;
      @(posedge CLK); #1;
      check("bounce_col_next", 32'(col), 'hD);
      check("bounce_held", 32'(key_held), 0);
      repeat (3) @(posedge CLK);
      #1 check("bounce_dwell", 32'(col), 'hD);
      @(posedge CLK);
      #1 check("bounce_advance", 32'(col), 'hB);
      check("bounce_entry", 32'(entry), 'h0009);

      // Key sequence, clears and the release glitch
      for (int i = 0; i < 10; i++) begin
         case (kt[i].op)
            0: press(kt[i].code, 1'b0, 1'b0);
            1: press(kt[i].code, 1'b1, 1'b0);
            3: press(kt[i].code, 1'b0, 1'b1);
            default: begin
               @(posedge CLK);
               #1 clear = 1'b1;
               @(posedge CLK);
               #1 clear = 1'b0;
               sb_entry = 16'h0000;
            end
         endcase
         check("table_entry", 32'(entry), 32'(kt[i].exp_entry));
      end

      // Reset in the middle of a press debounce
      sync_col(4'b1011);
      key_r    = 2'd0;
      key_c    = 2'd2;
      key_down = 1'b1;
      repeat (6) @(posedge CLK);
      #1 RESET = 1'b1;
      #1;
      check("mid_rst_col", 32'(col), 'hE);
      check("mid_rst_code", 32'(key_code), 0);
      check("mid_rst_valid", 32'(key_valid), 0);
      check("mid_rst_held", 32'(key_held), 0);
      check("mid_rst_entry", 32'(entry), 0);
      key_down = 1'b0;
      sb_entry = 16'h0000;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      repeat (40) @(posedge CLK);
      #1;
      check("post_rst_held", 32'(key_held), 0);
      check("post_rst_entry", 32'(entry), 0);

      check("sb_empty", 32'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
